locker_slot_manager: RTL and testbench

Compartment allocation and pickup-code controller for the express box. It tracks occupancy of the 16 compartments shown on the LED bank. On a deposit it assigns the lowest free compartment a 16-bit pickup code. On a retrieval it scans the stored codes for a match and frees that compartment. Inputs come from the debounced panel buttons; outputs drive the top-level Mealy/display logic.

---
 rtl/locker_slot_manager_if.sv | 28 ++
 rtl/locker_slot_manager.sv | 198 +++++++++++++++++++
 tb/tb_locker_slot_manager.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/locker_slot_manager_if.sv
// Panel/display bus for locker_slot_manager.
//   master : panel side; drives req_store, req_fetch and code_in, reads status.
//   slave  : slot manager; reads requests, drives occupied, full, busy, done,
//            err, slot_idx, code_out, locked and fail_cnt.
interface locker_slot_manager_if;
  logic        req_store;
  logic        req_fetch;
  logic [15:0] code_in;
  logic [15:0] occupied;
  logic        full;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  slot_idx;
  logic [15:0] code_out;
  logic        locked;
  logic [1:0]  fail_cnt;

  modport master (
    output req_store, req_fetch, code_in,
    input  occupied, full, busy, done, err, slot_idx, code_out, locked, fail_cnt
  );

  modport slave (
    input  req_store, req_fetch, code_in,
    output occupied, full, busy, done, err, slot_idx, code_out, locked, fail_cnt
  );
endinterface

// File: rtl/locker_slot_manager.sv
// Compartment allocation and pickup-code controller for the express box.
// Stores take the lowest free compartment and issue an LFSR pickup code in one
// cycle; fetches scan the 16 stored codes one slot per cycle and free the
// lowest matching occupied compartment.
// Ports:
//   clk     : system clock
//   restart : synchronous active-high reset
//   bus     : locker_slot_manager_if.slave (requests in, status out)
// Build option: define LOCKOUT_EN to enable the LOCK state (MAX_FAIL
// consecutive misses lock the panel for LOCK_CYCLES clocks). Without it,
// fail_cnt saturates at 3 and locked is tied low.
module locker_slot_manager #(
  parameter int unsigned NSLOT       = 16,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 50000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                   clk,
  input logic                   restart,
  locker_slot_manager_if.slave  bus
);

  if (LFSR_SEED == 16'h0000 || MAX_FAIL == 0 || MAX_FAIL > 3 || LOCK_CYCLES == 0 || NSLOT != 16) begin : g_cfg_err
    $error("locker_slot_manager: invalid parameter set");
  end

`ifdef LOCKOUT_EN
  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOCK} state_t;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q;
`else
  typedef enum logic {S_IDLE, S_SCAN} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] occ_q, occ_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] key_q, key_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  fail_q, fail_d;
  logic [3:0]  slot_q, slot_d;
  logic [15:0] code_out_q, code_out_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, full_q;
  logic [15:0] mem_q [NSLOT];
  logic        mem_we;
  logic [3:0]  free_idx;
  logic [15:0] lfsr_next;

  // Descending loop so the lowest free index is the one that sticks.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = NSLOT; i > 0; i--) begin
      if (!occ_q[i-1]) free_idx = 4'(i - 1);
    end
  end

  // Right-shift Fibonacci form of taps 16,14,13,11.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    lfsr_d     = lfsr_q;
    key_d      = key_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    slot_d     = slot_q;
    code_out_d = code_out_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
`ifdef LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Fetch has priority; a simultaneous store is dropped.
        if (bus.req_fetch) begin
          if (occ_q == '0) begin
            err_d = 1'b1;
          end else begin
            key_d   = bus.code_in;
            idx_d   = '0;
            state_d = S_SCAN;
          end
        end else if (bus.req_store) begin
          if (occ_q == '1) begin
            err_d = 1'b1;
          end else begin
            occ_d[free_idx] = 1'b1;
            mem_we          = 1'b1;
            slot_d          = free_idx;
            code_out_d      = lfsr_q;
            done_d          = 1'b1;
            lfsr_d          = lfsr_next;
          end
        end
      end
      S_SCAN: begin
        if (occ_q[idx_q] && mem_q[idx_q] == key_q) begin
          occ_d[idx_q] = 1'b0;
          slot_d       = idx_q;
          done_d       = 1'b1;
          fail_d       = '0;
          state_d      = S_IDLE;
        end else if (idx_q == 4'(NSLOT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef LOCKOUT_EN
          fail_d = fail_q + 2'd1;
          if ({1'b0, fail_q} + 3'd1 == 3'(MAX_FAIL)) begin
            state_d    = S_LOCK;
            lock_cnt_d = '0;
          end
`else
          if (fail_q != '1) fail_d = fail_q + 2'd1;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`ifdef LOCKOUT_EN
      S_LOCK: begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      key_q      <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      slot_q     <= '0;
      code_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      lfsr_q     <= lfsr_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      slot_q     <= slot_d;
      code_out_q <= code_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
      full_q     <= (occ_d == '1);
    end
  end

  // Code memory is not reset; occupancy gates every comparison.
  always_ff @(posedge clk) begin
    if (!restart && mem_we) mem_q[free_idx] <= lfsr_q;
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (restart) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (state_d == S_LOCK);
    end
  end
  assign bus.locked = locked_q;
`else
  assign bus.locked = 1'b0;
`endif

  assign bus.occupied = occ_q;
  assign bus.full     = full_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.slot_idx = slot_q;
  assign bus.code_out = code_out_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_locker_slot_manager.sv
// Directed self-checking bench for locker_slot_manager (LOCK_CYCLES = 8).
module tb_locker_slot_manager;
  logic clk = 1'b0;
  logic restart;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   lat;
  int   lock_len;
  logic saw_done;

  locker_slot_manager_if bus ();

  locker_slot_manager #(.LOCK_CYCLES(8)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the request edge to the done/err edge; -1 on timeout.
  task automatic wait_pulse(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.done || bus.err) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic do_store();
    bus.req_store = 1'b1;
    tick();
    bus.req_store = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] code);
    bus.code_in   = code;
    bus.req_fetch = 1'b1;
    tick();
    bus.req_fetch = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] codes [3];
    codes[0] = 16'hACE1;
    codes[1] = 16'h5670;
    codes[2] = 16'hAB38;

    bus.req_store = 1'b0;
    bus.req_fetch = 1'b0;
    bus.code_in   = '0;
    restart       = 1'b1;
    tick();
    tick();
    restart = 1'b0;

    // Reset state
    chk("rst_occ",    bus.occupied, 32'h0);
    chk("rst_busy",   bus.busy,     32'h0);
    chk("rst_done",   bus.done,     32'h0);
    chk("rst_err",    bus.err,      32'h0);
    chk("rst_code",   bus.code_out, 32'h0);
    chk("rst_slot",   bus.slot_idx, 32'h0);
    chk("rst_fail",   bus.fail_cnt, 32'h0);
    chk("rst_locked", bus.locked,   32'h0);
    chk("rst_full",   bus.full,     32'h0);

    // First store
    do_store();
    chk("st1_done", bus.done,     32'h1);
    chk("st1_slot", bus.slot_idx, 32'h0);
    chk("st1_code", bus.code_out, 32'hACE1);
    chk("st1_occ",  bus.occupied, 32'h0001);
    chk("st1_busy", bus.busy,     32'h0);
    tick();
    chk("st1_pulse", bus.done, 32'h0);

    // Fill remaining 15 back-to-back, then a 17th store while full
    bus.req_store = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("fill_done", bus.done, 32'h1);
      chk("fill_slot", bus.slot_idx, 32'(i));
      if (i == 1) chk("fill_code2", bus.code_out, 32'h5670);
    end
    chk("fill_occ",  bus.occupied, 32'hFFFF);
    chk("fill_full", bus.full,     32'h1);
    tick();
    bus.req_store = 1'b0;
    chk("st17_err",  bus.err,      32'h1);
    chk("st17_done", bus.done,     32'h0);
    chk("st17_occ",  bus.occupied, 32'hFFFF);

    // Restart, three stores, fetch slot 2
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst2_occ", bus.occupied, 32'h0);
    for (int i = 0; i < 3; i++) begin
      do_store();
      chk("st3_code", bus.code_out, 32'(codes[i]));
    end
    chk("st3_occ", bus.occupied, 32'h0007);
    do_fetch(codes[2]);
    chk("f2_busy", bus.busy, 32'h1);
    chk("f2_done0", bus.done, 32'h0);
    wait_pulse(lat);
    chk("f2_lat",  32'(lat),      32'd3);
    chk("f2_done", bus.done,      32'h1);
    chk("f2_slot", bus.slot_idx,  32'h2);
    chk("f2_occ",  bus.occupied,  32'h0003);
    chk("f2_busy_end", bus.busy,  32'h0);

    // Three misses
    for (int m = 1; m <= 3; m++) begin
      do_fetch(16'h0000);
      wait_pulse(lat);
      chk("miss_lat",  32'(lat),     32'd16);
      chk("miss_err",  bus.err,      32'h1);
      chk("miss_fail", bus.fail_cnt, 32'(m));
    end
`ifdef LOCKOUT_EN
    chk("lock_rise", bus.locked, 32'h1);
    lock_len = 0;
    saw_done = 1'b0;
    bus.code_in   = codes[0];
    bus.req_fetch = 1'b1;
    while (bus.locked && lock_len < 50) begin
      lock_len++;
      tick();
      bus.req_fetch = 1'b0;
      if (bus.done) saw_done = 1'b1;
    end
    chk("lock_len",     32'(lock_len),  32'd8);
    chk("lock_ignored", 32'(saw_done),  32'h0);
    chk("lock_fail",    bus.fail_cnt,   32'h0);
    chk("lock_occ",     bus.occupied,   32'h0003);
    chk("lock_busy",    bus.busy,       32'h0);
`else
    chk("nolock_locked", bus.locked, 32'h0);
    do_fetch(16'h0000);
    wait_pulse(lat);
    chk("sat_err",  bus.err,      32'h1);
    chk("sat_fail", bus.fail_cnt, 32'h3);
    chk("sat_locked", bus.locked, 32'h0);
`endif

    // Successful fetch of slot 1 clears fail count
    do_fetch(codes[1]);
    wait_pulse(lat);
    chk("f1_lat",  32'(lat),     32'd2);
    chk("f1_slot", bus.slot_idx, 32'h1);
    chk("f1_fail", bus.fail_cnt, 32'h0);
    chk("f1_occ",  bus.occupied, 32'h0001);

    // Simultaneous store + fetch: fetch wins
    bus.code_in   = codes[0];
    bus.req_store = 1'b1;
    bus.req_fetch = 1'b1;
    tick();
    bus.req_store = 1'b0;
    bus.req_fetch = 1'b0;
    chk("both_busy",  bus.busy,     32'h1);
    chk("both_done0", bus.done,     32'h0);
    chk("both_occ0",  bus.occupied, 32'h0001);
    wait_pulse(lat);
    chk("both_lat",  32'(lat),     32'd1);
    chk("both_slot", bus.slot_idx, 32'h0);
    chk("both_occ",  bus.occupied, 32'h0000);

    // Empty fetch
    do_fetch(codes[0]);
    chk("empty_err",  bus.err,  32'h1);
    chk("empty_busy", bus.busy, 32'h0);
    tick();
    chk("empty_pulse", bus.err, 32'h0);

    // Restart in the middle of a scan
    do_store();
    do_fetch(16'h0000);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy_pre", bus.busy, 32'h1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("mid_busy", bus.busy,     32'h0);
    chk("mid_occ",  bus.occupied, 32'h0);
    chk("mid_done", bus.done,     32'h0);
    chk("mid_err",  bus.err,      32'h0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("mid_noerr", bus.err, 32'h0);
    end
    do_store();
    chk("mid_code", bus.code_out, 32'hACE1);
    chk("mid_slot", bus.slot_idx, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
